// File: rtl/nx_ia_mem_arb.sv
// Memory arbiter between N_HW hardware requesters and the indirect-access sw port.
// Define NX_IA_ARB_STATS_EN to build the saturating sw_wait_cnt stall counter.
module nx_ia_mem_arb #(
    parameter int N_HW        = 2,
    parameter int N_ENTRIES   = 1024,
    parameter int N_DATA_BITS = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_HW-1:0]                        i_hw_req,
    input  logic [N_HW-1:0]                        i_hw_we,
    input  logic [N_HW-1:0][$clog2(N_ENTRIES)-1:0] i_hw_add,
    input  logic [N_HW-1:0][N_DATA_BITS-1:0]       i_hw_wdat,
    output logic [N_HW-1:0]                        o_hw_gnt,
    output logic [N_HW-1:0]                        o_hw_rsp,
    input  logic                                   i_sw_cs,
    input  logic                                   i_sw_ce,
    input  logic                                   i_sw_we,
    input  logic [$clog2(N_ENTRIES)-1:0]           i_sw_add,
    input  logic [N_DATA_BITS-1:0]                 i_sw_wdat,
    input  logic                                   i_yield,
    input  logic                                   i_sw_reset,
    input  logic                                   i_sw_enable,
    output logic                                   o_grant,
    output logic                                   o_rsp,
    output logic [N_DATA_BITS-1:0]                 o_sw_rdat,
    output logic                                   o_sw_match,
    output logic                                   o_mem_cs,
    output logic                                   o_mem_ce,
    output logic                                   o_mem_we,
    output logic [$clog2(N_ENTRIES)-1:0]           o_mem_add,
    output logic [N_DATA_BITS-1:0]                 o_mem_wdat,
    input  logic [N_DATA_BITS-1:0]                 i_mem_rdat,
    input  logic                                   i_mem_match,
    output logic [N_DATA_BITS-1:0]                 o_hw_rdat,
    output logic [15:0]                            o_sw_wait_cnt
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int PW = (N_HW > 1) ? $clog2(N_HW) : 1;

    typedef enum logic [1:0] {NORMAL, SW_PRIO, LOCK} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_rr_ptr;
    logic                  w_lock;
    logic                  w_prio;
    logic                  w_found;
    logic                  w_sw_gnt;
    logic                  w_hw_gnt_en;
    logic                  w_read;
    logic [PW-1:0]         w_hw_idx;
    logic [N_HW-1:0]       w_hw_gnt;
    int                    w_idx;

    logic                  r_mem_cs;
    logic                  r_mem_ce;
    logic                  r_mem_we;
    logic [AW-1:0]         r_mem_add;
    logic [N_DATA_BITS-1:0] r_mem_wdat;

    logic [RD_LATENCY:0]   r_pipe_vld;
    logic [RD_LATENCY:0]   r_pipe_sw;
    logic [PW-1:0]         r_pipe_own [RD_LATENCY+1];
    logic                  w_out_vld;

    // sw_reset and a yield request take effect in the cycle they are seen, ahead of the state register.
    always_comb begin
        w_lock      = i_sw_reset || (r_state == LOCK);
        w_prio      = !w_lock && ((r_state == SW_PRIO) || ((r_state == NORMAL) && i_yield && i_sw_cs));
        w_found     = 1'b0;
        w_hw_idx    = '0;
        w_idx       = 0;
        w_sw_gnt    = 1'b0;
        w_hw_gnt_en = 1'b0;
        for (int k = 0; k < N_HW; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_HW) w_idx = w_idx - N_HW;
            if (!w_found && i_hw_req[PW'(w_idx)]) begin
                w_found  = 1'b1;
                w_hw_idx = PW'(w_idx);
            end
        end
        if (!rst_n) begin
            w_sw_gnt = 1'b0;
        end else if (w_lock) begin
            w_sw_gnt = i_sw_cs;
        end else if (w_prio && i_sw_cs) begin
            w_sw_gnt = 1'b1;
        end else if (i_sw_enable && w_found) begin
            w_hw_gnt_en = 1'b1;
        end else begin
            w_sw_gnt = i_sw_cs && i_sw_enable;
        end
        w_hw_gnt           = '0;
        w_hw_gnt[w_hw_idx] = w_hw_gnt_en;
        w_read             = w_sw_gnt ? !i_sw_we : (w_hw_gnt_en && !i_hw_we[w_hw_idx]);
    end

    assign o_hw_gnt = w_hw_gnt;
    assign o_grant  = w_sw_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= NORMAL;
            r_rr_ptr <= '0;
        end else begin
            if (i_sw_reset) begin
                r_state <= LOCK;
            end else begin
                case (r_state)
                    // A yield is normally granted immediately, so SW_PRIO is only held if that grant was withheld.
                    NORMAL:  if (i_yield && i_sw_cs && !w_sw_gnt) r_state <= SW_PRIO;
                    SW_PRIO: if (w_sw_gnt) r_state <= NORMAL;
                    LOCK:    r_state <= NORMAL;
                    default: r_state <= NORMAL;
                endcase
            end
            if (w_hw_gnt_en) begin
                r_rr_ptr <= (w_hw_idx == PW'(N_HW - 1)) ? '0 : w_hw_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cs   <= 1'b0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_add  <= '0;
            r_mem_wdat <= '0;
        end else if (w_sw_gnt) begin
            r_mem_cs   <= 1'b1;
            r_mem_ce   <= i_sw_ce;
            r_mem_we   <= i_sw_we;
            r_mem_add  <= i_sw_add;
            r_mem_wdat <= i_sw_wdat;
        end else if (w_hw_gnt_en) begin
            r_mem_cs   <= 1'b1;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= i_hw_we[w_hw_idx];
            r_mem_add  <= i_hw_add[w_hw_idx];
            r_mem_wdat <= i_hw_wdat[w_hw_idx];
        end else begin
            r_mem_cs   <= 1'b0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_add  <= '0;
            r_mem_wdat <= '0;
        end
    end

    assign o_mem_cs   = r_mem_cs;
    assign o_mem_ce   = r_mem_ce;
    assign o_mem_we   = r_mem_we;
    assign o_mem_add  = r_mem_add;
    assign o_mem_wdat = r_mem_wdat;

    // Read tracking pipe: stage RD_LATENCY lines up with the memory's read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_sw  <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) r_pipe_own[k] <= '0;
        end else begin
            r_pipe_vld    <= {r_pipe_vld[RD_LATENCY-1:0], w_read};
            r_pipe_sw     <= {r_pipe_sw[RD_LATENCY-1:0], w_sw_gnt};
            r_pipe_own[0] <= w_hw_idx;
            for (int k = 1; k <= RD_LATENCY; k++) r_pipe_own[k] <= r_pipe_own[k-1];
        end
    end

    assign w_out_vld = r_pipe_vld[RD_LATENCY];
    assign o_rsp     = w_out_vld && r_pipe_sw[RD_LATENCY];

    always_comb begin
        o_hw_rsp = '0;
        if (w_out_vld && !r_pipe_sw[RD_LATENCY]) o_hw_rsp[r_pipe_own[RD_LATENCY]] = 1'b1;
    end

    assign o_sw_rdat  = o_rsp ? i_mem_rdat : '0;
    assign o_hw_rdat  = (|o_hw_rsp) ? i_mem_rdat : '0;
    assign o_sw_match = o_rsp && i_mem_match;

`ifdef NX_IA_ARB_STATS_EN
    logic [15:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (i_sw_cs && !w_sw_gnt && (r_wait_cnt != 16'hFFFF)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign o_sw_wait_cnt = r_wait_cnt;
`else
    assign o_sw_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_nx_ia_mem_arb.sv
// Scoreboard bench for nx_ia_mem_arb (RD_LATENCY=2); stimulus pushes expectations, a negedge monitor checks them.
module tb_nx_ia_mem_arb;

    localparam int N_HW = 2;
    localparam int N_ENTRIES = 1024;
    localparam int DW = 32;
    localparam int RDL = 2;
    localparam int AW = 10;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        grant;
        logic [15:0] waitCnt;
    } gntExp_t;

    typedef struct {
        int          cyc;
        logic        cs;
        logic        ce;
        logic        we;
        logic [9:0]  add;
        logic [31:0] wdat;
    } memExp_t;

    typedef struct {
        int          cyc;
        logic        sw;
        logic [1:0]  hwRsp;
        logic [31:0] data;
        logic        match;
    } rspExp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N_HW-1:0]         hw_req;
    logic [N_HW-1:0]         hw_we;
    logic [N_HW-1:0][AW-1:0] hw_add;
    logic [N_HW-1:0][DW-1:0] hw_wdat;
    logic [N_HW-1:0]         hw_gnt;
    logic [N_HW-1:0]         hw_rsp;
    logic                    sw_cs, sw_ce, sw_we, yield, sw_reset, sw_enable;
    logic [AW-1:0]           sw_add;
    logic [DW-1:0]           sw_wdat;
    logic                    grant, rsp, sw_match;
    logic [DW-1:0]           sw_rdat;
    logic                    mem_cs, mem_ce, mem_we;
    logic [AW-1:0]           mem_add;
    logic [DW-1:0]           mem_wdat;
    logic [DW-1:0]           mem_rdat;
    logic                    mem_match;
    logic [DW-1:0]           hw_rdat;
    logic [15:0]             sw_wait_cnt;

    gntExp_t gntQ[$];
    memExp_t memQ[$];
    rspExp_t rspQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int waitModel = 0;

    nx_ia_mem_arb #(
        .N_HW(N_HW), .N_ENTRIES(N_ENTRIES), .N_DATA_BITS(DW), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_hw_req(hw_req), .i_hw_we(hw_we), .i_hw_add(hw_add), .i_hw_wdat(hw_wdat),
        .o_hw_gnt(hw_gnt), .o_hw_rsp(hw_rsp),
        .i_sw_cs(sw_cs), .i_sw_ce(sw_ce), .i_sw_we(sw_we), .i_sw_add(sw_add),
        .i_sw_wdat(sw_wdat), .i_yield(yield), .i_sw_reset(sw_reset), .i_sw_enable(sw_enable),
        .o_grant(grant), .o_rsp(rsp), .o_sw_rdat(sw_rdat), .o_sw_match(sw_match),
        .o_mem_cs(mem_cs), .o_mem_ce(mem_ce), .o_mem_we(mem_we), .o_mem_add(mem_add),
        .o_mem_wdat(mem_wdat), .i_mem_rdat(mem_rdat), .i_mem_match(mem_match),
        .o_hw_rdat(hw_rdat), .o_sw_wait_cnt(sw_wait_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: returns the expected read word exactly in the cycle the response is due.
    always @(posedge clk) begin
        #1;
        if (rspQ.size() > 0 && rspQ[0].cyc == cyc) begin
            mem_rdat  = rspQ[0].data;
            mem_match = rspQ[0].match;
        end else begin
            mem_rdat  = 32'h5A5A_0000 ^ 32'(cyc);
            mem_match = 1'b1;
        end
    end

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setIdle();
        hw_req = '0; hw_we = '1; sw_cs = 1'b0; sw_ce = 1'b0; sw_we = 1'b1;
        yield = 1'b0; sw_reset = 1'b0; sw_enable = 1'b1;
        hw_add = '0; hw_wdat = '0; sw_add = '0; sw_wdat = '0;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] hwWe, input logic cs,
                                 input logic swWe, input logic yld, input logic swRst, input logic en,
                                 input logic [1:0] expGnt, input logic expGrant);
        gntExp_t g;
        memExp_t m;
        rspExp_t r;
        int idx;
        @(posedge clk);
        #1;
        hw_req = req; hw_we = hwWe; sw_cs = cs; sw_we = swWe; sw_ce = cyc[0];
        yield = yld; sw_reset = swRst; sw_enable = en;
        for (int i = 0; i < N_HW; i++) begin
            hw_add[i]  = AW'(cyc * 2 + i);
            hw_wdat[i] = 32'(32'h1000_0000 + cyc * 4 + i);
        end
        sw_add  = AW'(1023 - cyc);
        sw_wdat = 32'(32'h2000_0000 + cyc);
        g.cyc = cyc; g.gnt = expGnt; g.grant = expGrant; g.waitCnt = 16'(waitModel);
        gntQ.push_back(g);
`ifdef NX_IA_ARB_STATS_EN
        if (cs && !expGrant && waitModel < 65535) waitModel++;
`endif
        m.cyc = cyc + 1; m.cs = 1'b0; m.ce = 1'b0; m.we = 1'b0; m.add = '0; m.wdat = '0;
        idx = expGnt[1] ? 1 : 0;
        if (expGrant) begin
            m.cs = 1'b1; m.ce = sw_ce; m.we = swWe; m.add = sw_add; m.wdat = sw_wdat;
        end else if (expGnt != 2'b00) begin
            m.cs = 1'b1; m.ce = 1'b0; m.we = hwWe[idx]; m.add = hw_add[idx]; m.wdat = hw_wdat[idx];
        end
        memQ.push_back(m);
        if (expGrant && !swWe) begin
            r.cyc = cyc + RDL + 1; r.sw = 1'b1; r.hwRsp = 2'b00; r.data = 32'hDEADBEEF; r.match = cyc[1];
            rspQ.push_back(r);
        end else if (!expGrant && expGnt != 2'b00 && !hwWe[idx]) begin
            r.cyc = cyc + RDL + 1; r.sw = 1'b0; r.hwRsp = expGnt; r.data = 32'(32'hC0DE_0000 + cyc);
            r.match = 1'b0;
            rspQ.push_back(r);
        end
    endtask

    task automatic checkOutput();
        gntExp_t g;
        memExp_t m;
        rspExp_t r;
        if (gntQ.size() > 0 && gntQ[0].cyc == cyc) begin
            g = gntQ.pop_front();
            compare("hw_gnt", 64'(hw_gnt), 64'(g.gnt));
            compare("grant", 64'(grant), 64'(g.grant));
            compare("sw_wait_cnt", 64'(sw_wait_cnt), 64'(g.waitCnt));
        end
        if (memQ.size() > 0 && memQ[0].cyc == cyc) begin
            m = memQ.pop_front();
            compare("mem_cs", 64'(mem_cs), 64'(m.cs));
            if (m.cs)
                compare("mem_bus", 64'({mem_ce, mem_we, mem_add, mem_wdat}),
                        64'({m.ce, m.we, m.add, m.wdat}));
        end
        if (rspQ.size() > 0 && rspQ[0].cyc == cyc) begin
            r = rspQ.pop_front();
            compare("rsp_flags", 64'({rsp, hw_rsp}), 64'({r.sw, r.hwRsp}));
            if (r.sw) begin
                compare("sw_rdat", 64'(sw_rdat), 64'(r.data));
                compare("sw_match", 64'(sw_match), 64'(r.match));
            end else begin
                compare("hw_rdat", 64'(hw_rdat), 64'(r.data));
            end
        end else if (rsp || (|hw_rsp)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp=%0b hw_rsp=%0b expected none (cycle %0d)",
                     rsp, hw_rsp, cyc);
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic checkResetOutputs(input string tag);
        compare({tag, "_hw_gnt"}, 64'(hw_gnt), 64'd0);
        compare({tag, "_grant"}, 64'(grant), 64'd0);
        compare({tag, "_rsp"}, 64'({rsp, hw_rsp}), 64'd0);
        compare({tag, "_mem"}, 64'({mem_cs, mem_ce, mem_we, mem_add}), 64'd0);
        compare({tag, "_mem_wdat"}, 64'(mem_wdat), 64'd0);
        compare({tag, "_wait_cnt"}, 64'(sw_wait_cnt), 64'd0);
    endtask

    initial begin
        setIdle();
        hw_req = 2'b11; sw_cs = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("init");
        setIdle();
        #1;
        rst_n = 1'b1;

        // Round-robin from reset, then hw beating a non-yielding sw request.
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        repeat (3) applyStimulus(2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        // Back-to-back reads from both hw ports and the sw port.
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        applyStimulus(2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b10, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        // Lock window with a read issued inside it.
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
        repeat (4) applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        applyStimulus(2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);

        // Async reset with that sw read still in flight; its response must never appear.
        @(posedge clk);
        #1;
        hw_req = 2'b11; sw_cs = 1'b1; sw_we = 1'b0;
        #2;
        rst_n = 1'b0;
        gntQ.delete(); memQ.delete(); rspQ.delete();
        waitModel = 0;
        #1;
        checkResetOutputs("async");
        @(posedge clk);
        #3;
        setIdle();
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        repeat (6) applyStimulus(2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        compare("pending_gnt", 64'(gntQ.size()), 64'd0);
        compare("pending_mem", 64'(memQ.size()), 64'd0);
        compare("pending_rsp", 64'(rspQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nx_ia_mem_arb.md
NX_IA_MEM_ARB -- requirements
Module: nx_ia_mem_arb

Interface
REQ-001 Parameters (name, default, meaning): N_HW, 2, number of hardware requesters; N_ENTRIES, 1024, memory depth; N_DATA_BITS, 32, data width; RD_LATENCY, 1, memory read latency in cycles, legal range 1-4.
REQ-002 Ports, clock and reset first (name direction width meaning): clk in 1 clock; rst_n in 1 async active-low reset.
REQ-003 hw_req in N_HW, request; hw_we in N_HW, write; hw_add in N_HW x log2(N_ENTRIES), address; hw_wdat in N_HW x N_DATA_BITS, write data.
REQ-004 hw_gnt out N_HW, grant; hw_rsp out N_HW, read data valid.
REQ-005 sw_cs, sw_ce, sw_we in 1; sw_add in log2(N_ENTRIES); sw_wdat in N_DATA_BITS; yield in 1; sw_reset in 1; sw_enable in 1. These carry the indirect-access controller's port.
REQ-006 grant out 1; rsp out 1; sw_rdat out N_DATA_BITS; sw_match out 1.
REQ-007 mem_cs, mem_ce, mem_we out 1; mem_add out log2(N_ENTRIES); mem_wdat out N_DATA_BITS; mem_rdat in N_DATA_BITS; mem_match in 1.
REQ-008 hw_rdat out N_DATA_BITS, shared read data; sw_wait_cnt out 16.
REQ-009 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-010 At most one of grant or any hw_gnt bit is high per cycle; grants are combinational from the current request and state.
REQ-011 FSM states: NORMAL, SW_PRIO, LOCK.
REQ-012 NORMAL: requesting hw ports win, round-robin starting at rr_ptr; sw_cs is granted only when no hw_req is high and sw_enable is high.
REQ-013 NORMAL to SW_PRIO when yield and sw_cs are both high. In SW_PRIO, sw_cs wins unconditionally. SW_PRIO returns to NORMAL in the cycle after grant.
REQ-014 Any state to LOCK when sw_reset is high; this has priority over every other transition. In LOCK, all hw_gnt are 0 and sw_cs is granted every cycle. LOCK returns to NORMAL in the cycle after sw_reset falls.
REQ-015 When sw_enable is 0, all hw_gnt are 0; sw_cs is granted only in SW_PRIO or LOCK.
REQ-016 rr_ptr advances to winner+1 (mod N_HW) on each hw grant; otherwise it holds.
REQ-017 Memory outputs are registered from the winner's signals, one cycle after the grant. mem_ce is sw_ce for a sw winner and 0 for a hw winner.
REQ-018 Read tracking: each read grant (winner's we=0) pushes {valid, owner} into a RD_LATENCY+1 deep shift pipe.
REQ-019 Read response: rsp or hw_rsp[owner] pulses exactly RD_LATENCY+1 cycles after the grant. sw_rdat, hw_rdat and sw_match pass mem_rdat and mem_match through combinationally in that cycle.
REQ-020 Writes produce no rsp or hw_rsp.
REQ-021 Back-to-back grants every cycle are legal; the pipe carries one entry per cycle with no stall.
REQ-022 When hw_req and sw_cs arrive simultaneously with yield low, hw wins and the sw request waits.
REQ-023 sw_wait_cnt is governed by the configuration macro (REQ-028, REQ-029).

Reset
REQ-024 Under rst_n low: state=NORMAL, rr_ptr=0, pipe cleared, all mem_* outputs 0, grant/hw_gnt/rsp/hw_rsp 0, sw_wait_cnt 0.
REQ-025 Outstanding reads are discarded on reset; no rsp is generated after reset release for a pre-reset grant.
REQ-026 sw_reset does not clear the read pipe; in-flight reads complete normally.

Configuration
REQ-027 Macro NX_IA_ARB_STATS_EN.
REQ-028 Defined: sw_wait_cnt increments each cycle sw_cs is high without grant, saturates at 16'hFFFF, and clears on rst_n only.
REQ-029 Undefined: sw_wait_cnt is constant 0 and no counter logic is present.

Verification
REQ-030 Priority and wait: hw_req=2'b01, sw_cs=1, yield=0, sw_enable=1 for 3 cycles -> hw_gnt=01 each cycle, grant=0, sw_wait_cnt=3 (stats on).
REQ-031 Yield escalation: yield=1, sw_cs=1, hw_req=2'b11 -> grant=1 that cycle; next cycle state=NORMAL and hw_gnt resumes round-robin.
REQ-032 Round-robin: hw_req=2'b11 for 4 cycles from reset -> hw_gnt sequence 01,10,01,10.
REQ-033 Read latency: RD_LATENCY=2, sw read granted at cycle t with mem_rdat=32'hDEADBEEF at t+3 -> rsp=1 and sw_rdat=32'hDEADBEEF at t+3 only.
REQ-034 Lock: sw_reset=1 for 5 cycles with hw_req=2'b11 -> hw_gnt=0 and grant=1 throughout; hw_gnt=01 on the second cycle after sw_reset falls.
REQ-035 Async reset: rst_n low with a read in flight -> all outputs 0 immediately; no rsp after rst_n releases.
